// File: rtl/clip_indicator_if.sv
// Channel bus for the clip indicator: raw ADC overrange flags and display controls in,
// LED drive and event counters out.
interface clip_indicator_if #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 16
);
   logic [CHANNELS-1:0]       adc_overrange;
   logic [1:0]                mode;
   logic                      clear;
   logic [CHANNELS-1:0]       led_red;
   logic                      clip_any;
   logic [CHANNELS*CNT_W-1:0] clip_count;

   modport master (
      output adc_overrange, mode, clear,
      input  led_red, clip_any, clip_count
   );

   modport slave (
      input  adc_overrange, mode, clear,
      output led_red, clip_any, clip_count
   );
endinterface

// File: rtl/clip_indicator.sv
// Multi-channel clip indicator: synchronised overrange -> LED (hold/latch/blink) + saturating event count.
// LED and count respond two edges after the flag is sampled; no backpressure, host reads/clears any time.
module clip_indicator #(
   parameter int CHANNELS     = 2,
   parameter int HOLD_CYCLES  = 40000,
   parameter int BLINK_CYCLES = 4000,
   parameter int CNT_W        = 16
) (
   input logic         clock,
   input logic         reset,
   clip_indicator_if.slave bus
);
   localparam int TW = $clog2(HOLD_CYCLES + 1);
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [TW-1:0] HOLD_LD    = TW'(HOLD_CYCLES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [TW-1:0]    tmr_t;

   logic [CHANNELS-1:0] s1, s2, s3;
   logic [CHANNELS-1:0] clip_evt;
   logic [CHANNELS-1:0] latch_q, latch_nx;
   logic [CHANNELS-1:0] led_q, led_nx;
   logic                any_q;
   tmr_t                timer_q  [CHANNELS];
   tmr_t                timer_nx [CHANNELS];
   cnt_t                cnt_q    [CHANNELS];
   cnt_t                cnt_nx   [CHANNELS];
   logic [BW-1:0]       blink_cnt;
   logic                phase;

   assign clip_evt = s2 & ~s3;

   always_comb begin
      latch_nx = '0;
      led_nx   = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         timer_nx[ch] = '0;
         cnt_nx[ch]   = '0;
      end
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if (s2[ch])
            timer_nx[ch] = HOLD_LD;
         else if (timer_q[ch] != '0)
            timer_nx[ch] = timer_q[ch] - TW'(1);

         // A live overrange beats a simultaneous clear
         latch_nx[ch] = s2[ch] | (latch_q[ch] & ~bus.clear);

         case (bus.mode)
            2'd1:    led_nx[ch] = latch_nx[ch] | (timer_nx[ch] != '0);
            2'd2:    led_nx[ch] = (timer_nx[ch] != '0) & phase;
            default: led_nx[ch] = (timer_nx[ch] != '0);
         endcase

         if (bus.clear)
            cnt_nx[ch] = '0;
         else if (clip_evt[ch] && (cnt_q[ch] != '1))
            cnt_nx[ch] = cnt_q[ch] + cnt_t'(1);
         else
            cnt_nx[ch] = cnt_q[ch];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         latch_q   <= '0;
         led_q     <= '0;
         any_q     <= 1'b0;
         blink_cnt <= '0;
         phase     <= 1'b1;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            timer_q[ch] <= '0;
            cnt_q[ch]   <= '0;
         end
      end else begin
         s1      <= bus.adc_overrange;
         s2      <= s1;
         s3      <= s2;
         latch_q <= latch_nx;
         led_q   <= led_nx;
         any_q   <= |led_nx;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            timer_q[ch] <= timer_nx[ch];
            cnt_q[ch]   <= cnt_nx[ch];
         end
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   assign bus.led_red  = led_q;
   assign bus.clip_any = any_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
      assign bus.clip_count[g*CNT_W +: CNT_W] = cnt_q[g];
   end
endmodule
